regfile_wb_arbiter: RTL
=======================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the single regfile write port between N_REQ writeback sources (ALU=0, LSU=1, MDU=2).
//  Holds a 32-entry pending-write scoreboard so decode can stall on RAW/WAW hazards.
//  Sits between the execute-stage writeback outputs and the regfile i_rd_* port.
//  Output to the regfile is registered: one write per cycle, one cycle after acceptance.
// PARAMETERS
//  N_REQ   3   number of writeback requesters (2..8)
//  ADDR_W  5   register address width
//  DATA_W  32  register data width
// PORTS
//  i_clk       in   1             clock, all state updates on rising edge
//  i_reset_n   in   1             asynchronous reset, active-low
//  i_req_valid in   N_REQ         per-source writeback request
//  i_req_addr  in   N_REQ*ADDR_W  flattened rd addresses; source k at [k*ADDR_W +: ADDR_W]
//  i_req_data  in   N_REQ*DATA_W  flattened rd data; source k at [k*DATA_W +: DATA_W]
//  o_req_ready out  N_REQ         one-hot grant; transfer = valid & ready
//  o_rd_addr   out  ADDR_W        to regfile i_rd_addr
//  o_rd_data   out  DATA_W        to regfile i_rd_data
//  o_rd_wren   out  1             to regfile i_rd_wren
//  i_iss_valid in   1             decode issues an instruction that writes i_iss_rd
//  i_iss_rd    in   ADDR_W        destination of issuing instruction
//  o_iss_ready out  1             issue accepted this cycle (no WAW stall)
//  i_rs1_addr  in   ADDR_W        decode source operand 1
//  i_rs2_addr  in   ADDR_W        decode source operand 2
//  o_rs1_busy  out  1             rs1 has a pending write (RAW stall)
//  o_rs2_busy  out  1             rs2 has a pending write (RAW stall)
// BEHAVIOUR
//  Reset (async, i_reset_n=0): o_rd_wren=0, o_rd_addr=0, o_rd_data=0, busy[31:0]=0, rr_ptr=0.
//   Reset mid-operation drops any registered write and all pending bits; no write escapes.
//  Arbitration (combinational): at most one o_req_ready bit set, only for a valid source.
//   Search order starts at rr_ptr, wraps modulo N_REQ. No valid -> o_req_ready=0.
//   On transfer from source k: rr_ptr <= (k+1) mod N_REQ. No transfer -> rr_ptr holds.
//   A source must hold valid/addr/data stable until ready; ready never depends on its own data.
//  Output register: on transfer, next cycle o_rd_wren=(addr!=0), o_rd_addr/o_rd_data=granted values.
//   No transfer -> o_rd_wren=0; addr/data hold. Latency accept->regfile write edge = 1 cycle.
//   addr 0 requests are accepted (ready=1) but never produce o_rd_wren.
//  Scoreboard busy[31:0], busy[0] constant 0:
//   set busy[i_iss_rd] when i_iss_valid & o_iss_ready & i_iss_rd!=0.
//   clear busy[o_rd_addr] when o_rd_wren=1 (same edge the regfile writes).
//   set and clear of the same bit in one cycle -> set wins.
//   o_iss_ready = !busy[i_iss_rd] | (o_rd_wren & o_rd_addr==i_iss_rd) | (i_iss_rd==0).
//   Writeback to a non-busy register is legal; busy bit stays 0.
//  o_rsN_busy = busy[i_rsN_addr] (combinational); address 0 always reports 0.
//   Busy clears on the cycle after the regfile holds the new value; no bypass path.
// CONFIGURATION
//  WB_ARB_RR_EN defined: round-robin arbitration as above.
//  WB_ARB_RR_EN undefined: fixed priority, lowest index wins (ALU > LSU > MDU); rr_ptr removed.
//   All other behaviour identical.
// TESTING
//  1 Reset: drive i_reset_n=0 mid-write -> o_rd_wren=0, all busy=0, rr_ptr=0 immediately.
//  2 Single write: src1 valid addr=5 data=0xDEADBEEF -> ready[1]=1; next cycle wren=1, addr=5, data=0xDEADBEEF.
//  3 Contention (RR_EN): all 3 valid, held 3 cycles -> grants 0,1,2; without RR_EN -> 0,0,0.
//  4 x0 write: src0 addr=0 data=0x1234 -> ready[0]=1; next cycle o_rd_wren=0.
//  5 Scoreboard: issue rd=7 -> busy[7]=1, rs1=7 busy=1; writeback rd=7 -> busy clears edge after wren.
//  6 WAW same cycle: busy[7]=1, o_rd_wren=1 addr=7, issue rd=7 -> o_iss_ready=1, busy[7] stays 1.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the single regfile write port, with a pending-write scoreboard for decode stalls.
// Define WB_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module regfile_wb_arbiter #(
   parameter int unsigned N_REQ  = 3,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DATA_W = 32
) (
   input  logic                      i_clk,
   input  logic                      i_reset_n,
   input  logic [N_REQ-1:0]          i_req_valid,
   input  logic [N_REQ*ADDR_W-1:0]   i_req_addr,
   input  logic [N_REQ*DATA_W-1:0]   i_req_data,
   output logic [N_REQ-1:0]          o_req_ready,
   output logic [ADDR_W-1:0]         o_rd_addr,
   output logic [DATA_W-1:0]         o_rd_data,
   output logic                      o_rd_wren,
   input  logic                      i_iss_valid,
   input  logic [ADDR_W-1:0]         i_iss_rd,
   output logic                      o_iss_ready,
   input  logic [ADDR_W-1:0]         i_rs1_addr,
   input  logic [ADDR_W-1:0]         i_rs2_addr,
   output logic                      o_rs1_busy,
   output logic                      o_rs2_busy
);
   localparam int unsigned N_REG = 1 << ADDR_W;
   localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [N_REQ-1:0]  grant;
   logic [PTR_W-1:0]  grant_idx;
   logic              xfer;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_data;
   logic [N_REG-1:0]  busy;
   logic [N_REG-1:0]  busy_nxt;
   logic              iss_fire;

`ifdef WB_ARB_RR_EN
   logic [PTR_W-1:0]  rr_ptr;
   int unsigned       cand;
   logic [PTR_W-1:0]  cand_idx;

   // Round-robin search starting at rr_ptr, wrapping modulo N_REQ
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      xfer      = 1'b0;
      cand      = 0;
      cand_idx  = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         cand = 32'(rr_ptr) + i;
         if (cand >= N_REQ) cand = cand - N_REQ;
         cand_idx = PTR_W'(cand);
         if (!xfer && i_req_valid[cand_idx]) begin
            xfer            = 1'b1;
            grant_idx       = cand_idx;
            grant[cand_idx] = 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n)
         rr_ptr <= '0;
      else if (xfer)
         rr_ptr <= (32'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + 1'b1;
   end
`else
   logic [PTR_W-1:0]  idx;

   // Fixed priority: lowest valid index wins
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      xfer      = 1'b0;
      idx       = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         idx = PTR_W'(i);
         if (!xfer && i_req_valid[idx]) begin
            xfer       = 1'b1;
            grant_idx  = idx;
            grant[idx] = 1'b1;
         end
      end
   end
`endif

   assign o_req_ready = grant;
   assign sel_addr    = i_req_addr[32'(grant_idx) * ADDR_W +: ADDR_W];
   assign sel_data    = i_req_data[32'(grant_idx) * DATA_W +: DATA_W];

   // Registered regfile write; x0 writes are accepted but suppressed here
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         o_rd_wren <= 1'b0;
         o_rd_addr <= '0;
         o_rd_data <= '0;
      end else if (xfer) begin
         o_rd_wren <= (sel_addr != '0);
         o_rd_addr <= sel_addr;
         o_rd_data <= sel_data;
      end else begin
         o_rd_wren <= 1'b0;
      end
   end

   // A write retiring in the same cycle as a new issue to that register frees the slot
   assign o_iss_ready = ~busy[i_iss_rd] | (o_rd_wren & (o_rd_addr == i_iss_rd)) | (i_iss_rd == '0);
   assign iss_fire    = i_iss_valid & o_iss_ready & (i_iss_rd != '0);

   // Clear on regfile write, then set on issue so a same-cycle set wins
   always_comb begin
      busy_nxt = busy;
      if (o_rd_wren) busy_nxt[o_rd_addr] = 1'b0;
      if (iss_fire)  busy_nxt[i_iss_rd]  = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n)
         busy <= '0;
      else
         busy <= busy_nxt;
   end

   assign o_rs1_busy = busy[i_rs1_addr];
   assign o_rs2_busy = busy[i_rs2_addr];
endmodule
